// File: rtl/control_unit.sv
// Control sequencer for the single-cycle datapath: decodes the ROM word and status
// flags into datapath controls, and adds fetch wait, two-cycle load, halt and a retire count.
module control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst,
  input  logic [3:0]       status,
  output logic             RegWrite,
  output logic             PCSrc,
  output logic             ALUSrc,
  output logic [3:0]       ALU_operation,
  output logic             write,
  output logic             MemtoReg,
  output logic [1:0]       immselect,
  output logic             pc_hold,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    FETCH_WAIT = 2'd0,
    RUN        = 2'd1,
    LOAD_WB    = 2'd2,
    HALT       = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    K_RTYPE, K_IALU, K_LOAD, K_STORE, K_BRANCH, K_SYSTEM, K_ILLEGAL
  } kind_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t     state, state_next;
  kind_t      kind;
  logic [3:0] alu_op;
  logic       take;

  wire [6:0] opcode = inst[6:0];
  wire [2:0] funct3 = inst[14:12];
  wire       f7     = inst[30];
  wire       flag_z = status[0];
  wire       lt     = status[1] ^ status[3];

  // Decode relies on case matching: any X/Z bit in a decoded field fails every
  // item and lands in the default, so an unknown word decodes as illegal.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    kind   = K_ILLEGAL;
    alu_op = ALU_ADD;
    take   = 1'b0;
    case (opcode)
      7'b0110011: begin
        kind = K_RTYPE;
        case (funct3)
          3'b000: begin
            case (f7)
              1'b0:    alu_op = ALU_ADD;
              1'b1:    alu_op = ALU_SUB;
              default: kind   = K_ILLEGAL;
            endcase
          end
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b010:  alu_op = ALU_SLT;
          default: kind   = K_ILLEGAL;
        endcase
      end
      7'b0010011: begin
        kind = K_IALU;
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b010:  alu_op = ALU_SLT;
          default: kind   = K_ILLEGAL;
        endcase
      end
      7'b0000011: if (funct3 === 3'b010) kind = K_LOAD;
      7'b0100011: if (funct3 === 3'b010) kind = K_STORE;
      7'b1100011: begin
        kind = K_BRANCH;
        case (funct3)
          3'b000:  take = flag_z;
          3'b001:  take = !flag_z;
          3'b100:  take = lt;
          3'b101:  take = !lt;
          default: kind = K_ILLEGAL;
        endcase
      end
      7'b1110011: kind = K_SYSTEM;
      default:    kind = K_ILLEGAL;
    endcase
  end

  // NOTE: state is reset asynchronously and updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH_WAIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH_WAIT: state_next = RUN;
      RUN: begin
        case (kind)
          K_LOAD:              state_next = LOAD_WB;
          K_SYSTEM, K_ILLEGAL: state_next = HALT;
          default:             state_next = RUN;
        endcase
      end
      LOAD_WB: state_next = RUN;
      HALT:    state_next = HALT;
      default: state_next = FETCH_WAIT;
    endcase
  end

  always_comb begin
    RegWrite      = 1'b0;
    PCSrc         = 1'b0;
    ALUSrc        = 1'b0;
    ALU_operation = ALU_ADD;
    write         = 1'b0;
    MemtoReg      = 1'b1;
    immselect     = 2'b00;
    pc_hold       = 1'b0;
    halted        = 1'b0;
    case (state)
      FETCH_WAIT: pc_hold = 1'b1;
      RUN: begin
        case (kind)
          K_RTYPE: begin
            RegWrite      = 1'b1;
            ALU_operation = alu_op;
          end
          K_IALU: begin
            RegWrite      = 1'b1;
            ALUSrc        = 1'b1;
            ALU_operation = alu_op;
          end
          K_LOAD: begin
            ALUSrc  = 1'b1;
            pc_hold = 1'b1;
          end
          K_STORE: begin
            write     = 1'b1;
            ALUSrc    = 1'b1;
            immselect = 2'b01;
          end
          K_BRANCH: begin
            ALU_operation = ALU_SUB;
            immselect     = 2'b10;
            PCSrc         = take;
          end
          // The PC stays on a halting instruction rather than stepping past it.
          default: pc_hold = 1'b1;
        endcase
      end
      LOAD_WB: begin
        ALUSrc   = 1'b1;
        MemtoReg = 1'b0;
        RegWrite = 1'b1;
      end
      default: begin
        pc_hold = 1'b1;
        halted  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      if (state == RUN && kind == K_ILLEGAL) illegal <= 1'b1;
      if ((state == RUN && kind inside {K_RTYPE, K_IALU, K_STORE, K_BRANCH}) ||
          state == LOAD_WB)
        retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed steps plus randomized instructions,
// compared against an instruction-level reference model.
module tb_control_unit;

  localparam int CNT_W = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      inst;
  logic [3:0]       status;
  logic             RegWrite, PCSrc, ALUSrc, write, MemtoReg, pc_hold, halted, illegal;
  logic [3:0]       ALU_operation;
  logic [1:0]       immselect;
  logic [CNT_W-1:0] retired;

  control_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .inst(inst), .status(status),
    .RegWrite(RegWrite), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .ALU_operation(ALU_operation),
    .write(write), .MemtoReg(MemtoReg), .immselect(immselect), .pc_hold(pc_hold),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: instruction-level view of the sequencer.
  bit m_fetch, m_load, m_halt, m_illegal;
  int m_retired;

  typedef enum int {R_OP, I_OP, LW_OP, SW_OP, BR_OP, SYS_OP, BAD_OP} cls_t;

  function automatic cls_t classify(input logic [31:0] i);
    int op, f3;
    if ($isunknown(i)) return BAD_OP;
    op = i & 32'h7f;
    f3 = (i >> 12) & 7;
    case (op)
      'h33: return (f3 inside {0, 2, 6, 7}) ? R_OP : BAD_OP;
      'h13: return (f3 inside {0, 2, 6, 7}) ? I_OP : BAD_OP;
      'h03: return (f3 == 2) ? LW_OP : BAD_OP;
      'h23: return (f3 == 2) ? SW_OP : BAD_OP;
      'h63: return (f3 inside {0, 1, 4, 5}) ? BR_OP : BAD_OP;
      'h73: return SYS_OP;
      default: return BAD_OP;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [31:0] i, input bit is_r);
    case ((i >> 12) & 7)
      0:       return (is_r && i[30]) ? 4'b0110 : 4'b0010;
      7:       return 4'b0000;
      6:       return 4'b0001;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic bit taken(input logic [31:0] i, input logic [3:0] s);
    bit z, lt;
    z  = s[0];
    lt = (s[1] != s[3]);
    case ((i >> 12) & 7)
      0:       return z;
      1:       return !z;
      4:       return lt;
      default: return !lt;
    endcase
  endfunction

  // Packed {RegWrite,PCSrc,ALUSrc,ALU_operation,write,MemtoReg,immselect,pc_hold,halted}
  function automatic logic [12:0] expect_ctl(input logic [31:0] i, input logic [3:0] s);
    bit rw = 0, pcs = 0, asrc = 0, wr = 0, m2r = 1, hold = 0, hlt = 0;
    logic [3:0] alu = 4'b0010;
    logic [1:0] imm = 2'b00;
    if (m_halt) begin
      hold = 1; hlt = 1;
    end else if (m_fetch) begin
      hold = 1;
    end else if (m_load) begin
      asrc = 1; m2r = 0; rw = 1;
    end else begin
      case (classify(i))
        R_OP:  begin rw = 1; alu = alu_of(i, 1); end
        I_OP:  begin rw = 1; asrc = 1; alu = alu_of(i, 0); end
        LW_OP: begin asrc = 1; hold = 1; end
        SW_OP: begin wr = 1; asrc = 1; imm = 2'b01; end
        BR_OP: begin alu = 4'b0110; imm = 2'b10; pcs = taken(i, s); end
        default: hold = 1;
      endcase
    end
    return {rw, pcs, asrc, alu, wr, m2r, imm, hold, hlt};
  endfunction

  task automatic model_reset();
    m_fetch = 1; m_load = 0; m_halt = 0; m_illegal = 0; m_retired = 0;
  endtask

  task automatic model_clock(input logic [31:0] i);
    if (m_halt) return;
    if (m_fetch) m_fetch = 0;
    else if (m_load) begin
      m_load = 0;
      m_retired = (m_retired + 1) % (1 << CNT_W);
    end else begin
      case (classify(i))
        LW_OP:  m_load = 1;
        SYS_OP: m_halt = 1;
        BAD_OP: begin m_halt = 1; m_illegal = 1; end
        default: m_retired = (m_retired + 1) % (1 << CNT_W);
      endcase
    end
  endtask

  wire [12:0] ctl = {RegWrite, PCSrc, ALUSrc, ALU_operation, write, MemtoReg,
                     immselect, pc_hold, halted};

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic step(input string tag, input logic [31:0] i, input logic [3:0] s);
    inst = i;
    status = s;
    #1;
    check({tag, ".ctl"}, 32'(ctl), 32'(expect_ctl(i, s)));
    @(posedge clk);
    model_clock(i);
    #1;
    check({tag, ".retired"}, 32'(retired), 32'(m_retired));
    check({tag, ".illegal"}, 32'(illegal), 32'(m_illegal));
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check({tag, ".rst_retired"}, 32'(retired), 32'd0);
    check({tag, ".rst_illegal"}, 32'(illegal), 32'd0);
    check({tag, ".rst_ctl"}, 32'(ctl), 32'(expect_ctl(NOP, 4'h0)));
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [9:0] legal_pairs [12] = '{
    {7'h33, 3'd0}, {7'h33, 3'd7}, {7'h33, 3'd6}, {7'h33, 3'd2},
    {7'h13, 3'd0}, {7'h13, 3'd2}, {7'h03, 3'd2}, {7'h23, 3'd2},
    {7'h63, 3'd0}, {7'h63, 3'd1}, {7'h63, 3'd4}, {7'h63, 3'd5}
  };

  initial begin
    logic [31:0] r;
    logic [9:0]  pr;
    reset  = 1'b1;
    inst   = NOP;
    status = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset("init");

    // Fetch wait, then ADDI retires
    step("fetch_wait", 32'h0050_0093, 4'h0);
    step("addi", 32'h0050_0093, 4'h0);
    check("addi.const_retired", 32'(retired), 32'd1);

    step("sub", 32'h4020_8133, 4'h0);
    step("and", 32'h0020_F133, 4'h0);
    step("or", 32'h0020_E133, 4'h0);
    step("slt", 32'h0020_A133, 4'h0);
    step("lw_a", 32'h0040_2183, 4'h0);
    step("lw_b", 32'h0040_2183, 4'h0);
    step("beq_t", 32'h0020_8463, 4'b0001);
    step("beq_nt", 32'h0020_8463, 4'b0000);
    step("bne", 32'h0020_9463, 4'b0000);
    step("blt", 32'h0020_C463, 4'b1010);
    step("bge", 32'h0020_D463, 4'b1010);
    step("sw", 32'h0030_A223, 4'h0);

    // Randomized legal instructions with random flags
    for (int n = 0; n < 300; n++) begin
      pr = legal_pairs[$urandom_range(0, 11)];
      r  = $urandom;
      step("rand", {r[31:15], pr[2:0], r[11:7], pr[9:3]}, 4'($urandom));
    end

    // Illegal opcode halts; halt holds and retired stays frozen
    step("ill_7f", 32'h0000_007F, 4'h0);
    step("halt1", NOP, 4'h0);
    step("halt2", 32'h4020_8133, 4'hF);
    do_reset("rst_halt");

    // Illegal load width, then ECALL halt without the illegal flag
    step("fw2", NOP, 4'h0);
    step("lb_ill", 32'h0040_0183, 4'h0);
    do_reset("rst2");
    step("fw3", NOP, 4'h0);
    step("br_ill", 32'h0020_A463, 4'h0);
    do_reset("rst3");
    step("fw4", NOP, 4'h0);
    step("ecall", 32'h0000_0073, 4'h0);
    step("ecall_halt", NOP, 4'h0);
    do_reset("rst4");
    step("fw5", NOP, 4'h0);
    step("x_inst", 32'hxxxx_xxxx, 4'h0);
    do_reset("rst5");

    // Fully random words until the core halts
    step("fw6", NOP, 4'h0);
    for (int n = 0; n < 40; n++) step("wild", $urandom, 4'($urandom));
    do_reset("rst6");

    // Reset while the second load cycle is pending
    step("fw7", NOP, 4'h0);
    inst = 32'h0040_2183;
    @(posedge clk);
    model_clock(inst);
    do_reset("rst_load");

    // Counter wrap
    step("fw8", NOP, 4'h0);
    inst = NOP;
    repeat (65535) begin
      @(posedge clk);
      model_clock(NOP);
    end
    @(negedge clk);
    check("wrap.pre", 32'(retired), 32'(m_retired));
    check("wrap.pre_const", 32'(retired), 32'h0000_FFFF);
    step("wrap", NOP, 4'h0);
    check("wrap.const", 32'(retired), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Control sequencer that sits directly upstream of the single-cycle datapath.
- Decodes the instruction word coming out of the ROM, together with the ALU status flags, and drives every datapath control input: RegWrite, PCSrc, ALUSrc, ALU_operation, write, MemtoReg, immselect.
- Adds sequencing the datapath lacks: a post-reset fetch wait, a two-cycle load for the synchronous RAM, halt on ECALL or an illegal opcode, and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- inst  input  32  instruction word from the ROM (ROM_inst).
- status  input  4  ALU flags: [0]=Z, [1]=N, [2]=C, [3]=V. Combinational, same cycle as ALU_out.
- RegWrite  output  1  register file write enable.
- PCSrc  output  1  0 = PC+4, 1 = PC+imm.
- ALUSrc  output  1  0 = rs2 value, 1 = imm.
- ALU_operation  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- write  output  1  RAM write enable.
- MemtoReg  output  1  0 = ReadData, 1 = ALU_out to the register file.
- immselect  output  2  00 = I-imm, 01 = S-imm, 10 = B-imm.
- pc_hold  output  1  1 = PC must not advance this cycle.
- halted  output  1  core halted.
- illegal  output  1  sticky flag: halt was caused by an undecodable instruction.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Clocking and reset:
  - Registered: state, illegal, retired. All control outputs are combinational from state, inst and status.
  - On reset: state = FETCH_WAIT, retired = 0, illegal = 0.
  - Reset is honoured mid-operation in any state, including LOAD_WB and HALT.
- Inactive output set: RegWrite=0, write=0, PCSrc=0, ALUSrc=0, ALU_operation=0010, MemtoReg=1, immselect=00.
- State FETCH_WAIT:
  - Drives the inactive set with pc_hold=1; gives the synchronous ROM one cycle to produce a valid word.
  - Next state: RUN.
- State RUN: decode inst[6:0], funct3 = inst[14:12], f7 = inst[30].
  - R-type 0110011: RegWrite=1, ALUSrc=0, MemtoReg=1.
    - ALU op: funct3 000 → ADD (f7=0) or SUB (f7=1); 111 → AND; 110 → OR; 010 → SLT.
  - I-ALU 0010011: RegWrite=1, ALUSrc=1, immselect=00, MemtoReg=1.
    - ALU op: 000 ADD, 111 AND, 110 OR, 010 SLT.
  - LW 0000011 (funct3 010): ALUSrc=1, immselect=00, ADD, RegWrite=0, pc_hold=1. Next state: LOAD_WB.
  - SW 0100011 (funct3 010): write=1, ALUSrc=1, immselect=01, ADD, RegWrite=0.
  - Branch 1100011: ALUSrc=0, SUB, immselect=10. PCSrc is evaluated the same cycle:
    - BEQ (000): Z.
    - BNE (001): !Z.
    - BLT (100): N^V.
    - BGE (101): !(N^V).
  - SYSTEM 1110011: inactive set. Next state: HALT.
  - Any other opcode/funct combination: inactive set, illegal<=1. Next state: HALT.
  - Non-load, non-halting instructions stay in RUN with pc_hold=0.
- State LOAD_WB:
  - Same ALU/imm selections as the LW cycle (address held stable), MemtoReg=0, RegWrite=1, pc_hold=0.
  - Next state: RUN.
- State HALT:
  - Inactive set, pc_hold=1, halted=1.
  - Exits only on reset.
- retired counter:
  - Increments on the clock edge that ends a RUN cycle for a completed non-load instruction (R, I, SW, branch taken or not), or that ends a LOAD_WB cycle.
  - Does not increment for SYSTEM, illegal, FETCH_WAIT or HALT.
  - Wraps from all-ones to 0.
- Decode rules:
  - Store/load with funct3 ≠ 010 is illegal.
  - Branch funct3 010, 011, 110, 111 is illegal.
  - X or Z on inst is treated as illegal (no X propagation to write/RegWrite).

Test Plan:
- Reset release, then ADDI x1,x0,5 (0x00500093) → cycle 0 after reset: FETCH_WAIT, pc_hold=1, RegWrite=0. Cycle 1: RegWrite=1, ALUSrc=1, ALU_operation=0010, retired 0→1.
- SUB R-type (0x40208133) → ALU_operation=0110, ALUSrc=0, MemtoReg=1. AND (funct3 111) → 0000. SLT (funct3 010) → 0111.
- LW x3,4(x0) (0x00402183) → cycle A: pc_hold=1, RegWrite=0, ALUSrc=1. Cycle B: MemtoReg=0, RegWrite=1, pc_hold=0. retired increments once, after B.
- BEQ with status=0001 → PCSrc=1, immselect=10. BEQ with status=0000 → PCSrc=0. BLT with status=1010 (N=1, V=1) → PCSrc=0. BGE with the same status → PCSrc=1.
- SW (0x0030A223) → write=1, RegWrite=0, immselect=01. Opcode 0x7F → illegal=1, halted=1, outputs inactive, retired frozen. Reset asserted during HALT → illegal=0, state FETCH_WAIT.
- Preload retired to 0xFFFF via 65535 NOPs (ADDI x0,x0,0), then one more → retired=0x0000.
